// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: Status, Cause, EPC, PRId, exception entry and eret updates.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_regs #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_0000,
    parameter logic [31:0] PRID_VALUE   = 32'h0000_0054
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr,
    output logic        timer_irq
);

    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegStatus  = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;
    localparam logic [4:0] RegPrid    = 5'd15;

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        ip7;
    logic [31:0] cause_word;
    logic [31:0] count_word;
    logic [31:0] compare_word;
    logic        wr_en;

    // A write only lands when no exception or eret claims the cycle.
    assign wr_en = mtc0 & ~exception & ~eret;

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        if (exception) begin
            epc_d      = pc;
            exc_code_d = cause;
            status_d   = {status_q[26:0], 5'b0};
        end else if (eret) begin
            status_d = {5'b0, status_q[31:5]};
        end else if (mtc0) begin
            case (rd)
                RegStatus: status_d   = wdata;
                RegCause:  exc_code_d = wdata[6:2];
                RegEpc:    epc_d      = wdata;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q   <= STATUS_RESET;
            epc_q      <= 32'h0;
            exc_code_q <= 5'h0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ip7_q, ip7_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ip7_d     = ip7_q;
        if (count_q == compare_q && compare_q != 32'h0) begin
            ip7_d = 1'b1;
        end
        if (wr_en) begin
            case (rd)
                RegCount:   count_d = wdata;
                RegCause:   ip7_d   = wdata[15];
                // Writing Compare acknowledges the interrupt, even against a same-cycle match.
                RegCompare: begin
                    compare_d = wdata;
                    ip7_d     = 1'b0;
                end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign ip7          = ip7_q;
    assign count_word   = count_q;
    assign compare_word = compare_q;
    assign timer_irq    = ip7_q & status_q[15] & status_q[0];
`else
    assign ip7          = 1'b0;
    assign count_word   = 32'h0;
    assign compare_word = 32'h0;
    assign timer_irq    = 1'b0;
`endif

    assign cause_word = {16'h0, ip7, 8'h0, exc_code_q, 2'b00};

    always_comb begin
        rdata = 32'h0;
        if (mfc0) begin
            case (rd)
                RegCount:   rdata = count_word;
                RegCompare: rdata = compare_word;
                RegStatus:  rdata = status_q;
                RegCause:   rdata = cause_word;
                RegEpc:     rdata = epc_q;
                RegPrid:    rdata = PRID_VALUE;
                default:    rdata = 32'h0;
            endcase
        end
    end

    assign status   = status_q;
    assign exc_addr = eret ? epc_q : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_regs.sv
// Table-driven bench for cp0_regs, plus hand sequences for reset priority and the timer.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        reset, mfc0, mtc0, exception, eret, timer_irq;
    logic [31:0] pc, wdata, rdata, status, exc_addr;
    logic [4:0]  rd, cause;
    int          errors = 0;
    int          checks = 0;

`ifdef CP0_TIMER_EN
    localparam logic [31:0] CauseAll = 32'h0000_807C;
`else
    localparam logic [31:0] CauseAll = 32'h0000_007C;
`endif

    typedef struct {
        logic        wr;
        logic        rdst;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        exc;
        logic        ert;
        logic [4:0]  cse;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        logic [31:0] exp_status;
        logic [31:0] exp_exc_addr;
    } vec_t;

    vec_t tbl[$];

    cp0_regs dut (
        .clk       (clk),
        .reset     (reset),
        .mfc0      (mfc0),
        .mtc0      (mtc0),
        .pc        (pc),
        .rd        (rd),
        .wdata     (wdata),
        .exception (exception),
        .eret      (eret),
        .cause     (cause),
        .rdata     (rdata),
        .status    (status),
        .exc_addr  (exc_addr),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic wr, input logic rdst, input logic [4:0] r,
                                input logic [31:0] wd, input logic exc, input logic ert,
                                input logic [4:0] cs, input logic [31:0] p,
                                input logic [31:0] er, input logic [31:0] es,
                                input logic [31:0] ea);
        vec_t v;
        v.wr = wr; v.rdst = rdst; v.rd = r; v.wdata = wd; v.exc = exc; v.ert = ert;
        v.cse = cs; v.pc = p; v.exp_rdata = er; v.exp_status = es; v.exp_exc_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wr, input logic rdst, input logic [4:0] r,
                         input logic [31:0] wd, input logic exc, input logic ert,
                         input logic [4:0] cs, input logic [31:0] p);
        reset = rst; mtc0 = wr; mfc0 = rdst; rd = r; wdata = wd;
        exception = exc; eret = ert; cause = cs; pc = p;
    endtask

    localparam logic [31:0] Vec = 32'h0040_0004;

    initial begin
        bit seen;
        // Columns: mtc0 mfc0 rd wdata exc eret cause pc | rdata status exc_addr
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'h0,        32'h0,        Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h0,        32'h0,        Vec));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h0,        32'h0,        Vec));
        tbl.push_back(mk(0, 1, 15, 0,            0, 0, 0,  0,         32'h54,       32'h0,        Vec));
        tbl.push_back(mk(1, 1, 12, 32'h1F,       0, 0, 0,  0,         32'h0,        32'h0,        Vec));
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'h1F,       32'h1F,       Vec));
        tbl.push_back(mk(1, 1, 15, 32'hDEAD,     0, 0, 0,  0,         32'h54,       32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 15, 0,            0, 0, 0,  0,         32'h54,       32'h1F,       Vec));
        tbl.push_back(mk(1, 1, 13, 32'hFFFFFFFF, 0, 0, 0,  0,         32'h0,        32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         CauseAll,     32'h1F,       Vec));
        tbl.push_back(mk(1, 1, 0,  0,            0, 0, 0,  0,         32'h0,        32'h1F,       Vec));
        tbl.push_back(mk(1, 1, 13, 0,            0, 0, 0,  0,         CauseAll,     32'h1F,       Vec));
        tbl.push_back(mk(1, 1, 3,  32'h1234,     0, 0, 0,  0,         32'h0,        32'h1F,       Vec));
        tbl.push_back(mk(0, 0, 12, 0,            0, 0, 0,  0,         32'h0,        32'h1F,       Vec));
        // exception entry: syscall
        tbl.push_back(mk(0, 1, 14, 0,            1, 0, 8,  32'h400020, 32'h0,       32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h400020,   32'h3E0,      Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h20,       32'h3E0,      Vec));
        tbl.push_back(mk(0, 1, 12, 0,            0, 1, 0,  0,         32'h3E0,      32'h3E0,      32'h400020));
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'h1F,       32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h400020,   32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h20,       32'h1F,       Vec));
        // exception beats a same-cycle mtc0
        tbl.push_back(mk(1, 1, 14, 32'hFFFF,     1, 0, 13, 32'h100,   32'h400020,   32'h1F,       Vec));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h100,      32'h3E0,      Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h34,       32'h3E0,      Vec));
        // three nested entries shift by 15, losing top bits
        tbl.push_back(mk(1, 1, 12, 32'hFFFFFFFF, 0, 0, 0,  0,         32'h3E0,      32'h3E0,      Vec));
        tbl.push_back(mk(0, 0, 0,  0,            1, 0, 9,  32'h200,   32'h0,        32'hFFFFFFFF, Vec));
        tbl.push_back(mk(0, 0, 0,  0,            1, 0, 9,  32'h204,   32'h0,        32'hFFFFFFE0, Vec));
        tbl.push_back(mk(0, 0, 0,  0,            1, 0, 9,  32'h208,   32'h0,        32'hFFFFFC00, Vec));
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'hFFFF8000, 32'hFFFF8000, Vec));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h208,      32'hFFFF8000, Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h24,       32'hFFFF8000, Vec));
        // exception and eret together: exception semantics, exc_addr shows EPC
        tbl.push_back(mk(0, 0, 0,  0,            1, 1, 8,  32'h300,   32'h0,        32'hFFFF8000, 32'h208));
        tbl.push_back(mk(0, 1, 14, 0,            0, 0, 0,  0,         32'h300,      32'hFFF00000, Vec));
        tbl.push_back(mk(0, 1, 13, 0,            0, 0, 0,  0,         32'h20,       32'hFFF00000, Vec));
        // eret drops a same-cycle mtc0
        tbl.push_back(mk(1, 0, 12, 32'h5,        0, 1, 0,  0,         32'h0,        32'hFFF00000, 32'h300));
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'h07FF8000, 32'h07FF8000, Vec));
        // rd above 15 is unimplemented, not an alias of rd-16
        tbl.push_back(mk(1, 1, 28, 32'h0,        0, 0, 0,  0,         32'h0,        32'h07FF8000, Vec));
        tbl.push_back(mk(0, 1, 12, 0,            0, 0, 0,  0,         32'h07FF8000, 32'h07FF8000, Vec));

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        foreach (tbl[i]) begin
            drive(0, tbl[i].wr, tbl[i].rdst, tbl[i].rd, tbl[i].wdata, tbl[i].exc, tbl[i].ert,
                  tbl[i].cse, tbl[i].pc);
            #1;
            check($sformatf("v%0d rdata", i), rdata, tbl[i].exp_rdata);
            check($sformatf("v%0d status", i), status, tbl[i].exp_status);
            check($sformatf("v%0d exc_addr", i), exc_addr, tbl[i].exp_exc_addr);
            check($sformatf("v%0d timer_irq", i), {31'h0, timer_irq}, 32'h0);
            @(negedge clk);
        end

        // reset overrides mtc0 and exception in the same cycle
        drive(1, 1, 0, 12, 32'hAAAA, 1, 0, 8, 32'h500);
        @(negedge clk);
        drive(0, 0, 1, 12, 0, 0, 0, 0, 0);
        #1 check("rst status", rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 13, 0, 0, 0, 0, 0);
        #1 check("rst cause", rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 14, 0, 0, 0, 0, 0);
        #1 check("rst epc", rdata, 32'h0);
        @(negedge clk);

`ifdef CP0_TIMER_EN
        drive(0, 1, 0, 12, 32'h8001, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 9, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 11, 32'd10, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (timer_irq) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("irq rise", {31'h0, seen}, 32'h1);
        drive(0, 0, 1, 9, 0, 0, 0, 0, 0);
        #1 check("count at irq", rdata, 32'd11);
        @(negedge clk);
        drive(0, 0, 1, 13, 0, 0, 0, 0, 0);
        #1 check("cause ip7 set", rdata, 32'h8000);
        @(negedge clk);
        drive(0, 1, 0, 11, 32'd50, 0, 0, 0, 0);
        #1 check("irq before ack", {31'h0, timer_irq}, 32'h1);
        @(negedge clk);
        drive(0, 0, 1, 13, 0, 0, 0, 0, 0);
        #1 check("irq after ack", {31'h0, timer_irq}, 32'h0);
        check("cause ip7 clr", rdata, 32'h0);
        @(negedge clk);
        drive(0, 1, 0, 9, 32'hFFFFFFFF, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 9, 0, 0, 0, 0, 0);
        #1 check("count max", rdata, 32'hFFFFFFFF);
        @(negedge clk);
        #1 check("count wrap", rdata, 32'h0);
        @(negedge clk);
`else
        drive(0, 1, 0, 12, 32'h8001, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 9, 32'h77, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 11, 32'h1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 9, 0, 0, 0, 0, 0);
        #1 check("count absent", rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 11, 0, 0, 0, 0, 0);
        #1 check("compare absent", rdata, 32'h0);
        check("irq absent", {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
